// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: sizes, adder opcodes,
// controller states and opcode decode helpers.
package calc_pkg;

    localparam int W    = 4;
    localparam int NREG = 4;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB_AB = 3'b001;
    localparam logic [2:0] OP_SUB_BA = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SIGN = 2'b01,
        EXEC = 2'b10,
        RESP = 2'b11
    } state_e;

    function automatic logic is_abs(input logic [2:0] op);
        logic res_s;
        case (op)
            3'b010, 3'b011, 3'b110, 3'b111: res_s = 1'b1;
            default:                        res_s = 1'b0;
        endcase
        return res_s;
    endfunction

    // 11x takes |A|, 01x takes |B|
    function automatic logic abs_of_a(input logic [2:0] op);
        logic res_s;
        case (op)
            3'b110, 3'b111: res_s = 1'b1;
            default:        res_s = 1'b0;
        endcase
        return res_s;
    endfunction

    function automatic logic [2:0] arith_op(input logic [2:0] op);
        logic [2:0] res_s;
        case (op)
            3'b001:  res_s = OP_SUB_AB;
            3'b101:  res_s = OP_SUB_BA;
            default: res_s = OP_ADD;
        endcase
        return res_s;
    endfunction

    // Signed overflow from the sign bits of minuend/addend m, subtrahend/addend s, result r
    function automatic logic signed_ovf(input logic is_sub, input logic m_msb,
                                        input logic s_msb, input logic r_msb);
        logic res_s;
        if (is_sub) begin
            res_s = (m_msb != s_msb) && (r_msb != m_msb);
        end else begin
            res_s = (m_msb == s_msb) && (r_msb != m_msb);
        end
        return res_s;
    endfunction

endpackage

// File: rtl/calc_regfile.sv
// Operand register file: one synchronous write port, two combinational read ports
// with latched copies captured on command accept, and a combinational debug read.
module calc_regfile #(
    parameter int W    = calc_pkg::W,
    parameter int NREG = calc_pkg::NREG
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_s,
    input  logic [1:0]   wr_addr_s,
    input  logic [W-1:0] wr_data_s,
    input  logic         rd_en_s,
    input  logic [1:0]   rd_a_addr_s,
    input  logic [1:0]   rd_b_addr_s,
    output logic [W-1:0] rd_a_data_s,
    output logic [W-1:0] rd_b_data_s,
    output logic [W-1:0] rd_a_q_r,
    output logic [W-1:0] rd_b_q_r,
    input  logic [1:0]   dbg_addr_s,
    output logic [W-1:0] dbg_data_s
);

    logic [W-1:0] mem_r [NREG];

    assign rd_a_data_s = mem_r[rd_a_addr_s];
    assign rd_b_data_s = mem_r[rd_b_addr_s];
    assign dbg_data_s  = mem_r[dbg_addr_s];

    // Storage and operand latches; reset wins over a same-edge write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
            rd_a_q_r <= {W{1'b0}};
            rd_b_q_r <= {W{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_addr_s] <= wr_data_s;
            end
            if (rd_en_s) begin
                rd_a_q_r <= mem_r[rd_a_addr_s];
                rd_b_q_r <= mem_r[rd_b_addr_s];
            end
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Command sequencer for the shared 4-bit adder: accepts one command at a time,
// drives the adder for ADD/SUB/ABS, writes back and returns result plus flags.
module calc_seq_ctrl #(
    parameter int NREG = calc_pkg::NREG,
    parameter int W    = calc_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_ld,
    input  logic [2:0]   cmd_op,
    input  logic [1:0]   cmd_dst,
    input  logic [1:0]   cmd_src_a,
    input  logic [1:0]   cmd_src_b,
    input  logic [W-1:0] cmd_imm,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_ovf,
    output logic         rsp_carry,
    output logic         rsp_err,
    output logic [W-1:0] alu_v1,
    output logic [W-1:0] alu_v2,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_r,
    input  logic         alu_ovf,
    input  logic [1:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    import calc_pkg::*;

    localparam logic [W-1:0] ZERO    = {W{1'b0}};
    localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

    state_e       state_r, state_nxt_s;
    logic         cmd_ready_r, rsp_valid_r;
    logic [W-1:0] rsp_data_r, rsp_data_nxt_s;
    logic         rsp_ovf_r, rsp_ovf_nxt_s;
    logic         rsp_carry_r, rsp_carry_nxt_s;
    logic         rsp_err_r, rsp_err_nxt_s;
    logic [W-1:0] alu_v1_r, alu_v1_nxt_s;
    logic [W-1:0] alu_v2_r, alu_v2_nxt_s;
    logic [2:0]   alu_op_r, alu_op_nxt_s;
    logic [1:0]   dst_r;
    logic [2:0]   op_r;

    logic         fire_s;
    logic         wr_en_s;
    logic [1:0]   wr_addr_s;
    logic [W-1:0] wr_data_s;
    logic [W-1:0] rd_a_s, rd_b_s, op_a_r, op_b_r;
    logic [W-1:0] abs_x_s;
    logic         exec_m_msb_s, exec_s_msb_s, exec_ovf_s;

    calc_regfile #(.W(W), .NREG(NREG)) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_s     (wr_en_s),
        .wr_addr_s   (wr_addr_s),
        .wr_data_s   (wr_data_s),
        .rd_en_s     (fire_s),
        .rd_a_addr_s (cmd_src_a),
        .rd_b_addr_s (cmd_src_b),
        .rd_a_data_s (rd_a_s),
        .rd_b_data_s (rd_b_s),
        .rd_a_q_r    (op_a_r),
        .rd_b_q_r    (op_b_r),
        .dbg_addr_s  (dbg_addr),
        .dbg_data_s  (dbg_data)
    );

    assign fire_s  = cmd_valid && cmd_ready_r;
    assign abs_x_s = abs_of_a(op_r) ? op_a_r : op_b_r;

    // The adder swaps operands for B-A, so the minuend is then v2
    assign exec_m_msb_s = (alu_op_r == OP_SUB_BA) ? alu_v2_r[W-1] : alu_v1_r[W-1];
    assign exec_s_msb_s = (alu_op_r == OP_SUB_BA) ? alu_v1_r[W-1] : alu_v2_r[W-1];
    assign exec_ovf_s   = signed_ovf(alu_op_r != OP_ADD, exec_m_msb_s, exec_s_msb_s, alu_r[W-1]);

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_ovf   = rsp_ovf_r;
    assign rsp_carry = rsp_carry_r;
    assign rsp_err   = rsp_err_r;
    assign alu_v1    = alu_v1_r;
    assign alu_v2    = alu_v2_r;
    assign alu_op    = alu_op_r;

    // Next state, write-back, next adder drive and next response fields
    always_comb begin
        state_nxt_s     = state_r;
        wr_en_s         = 1'b0;
        wr_addr_s       = dst_r;
        wr_data_s       = alu_r;
        alu_v1_nxt_s    = ZERO;
        alu_v2_nxt_s    = ZERO;
        alu_op_nxt_s    = OP_ADD;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_ovf_nxt_s   = rsp_ovf_r;
        rsp_carry_nxt_s = rsp_carry_r;
        rsp_err_nxt_s   = rsp_err_r;
        case (state_r)
            IDLE: begin
                if (!fire_s) begin
                    state_nxt_s = IDLE;
                end else if (cmd_ld) begin
                    state_nxt_s     = RESP;
                    wr_en_s         = 1'b1;
                    wr_addr_s       = cmd_dst;
                    wr_data_s       = cmd_imm;
                    rsp_data_nxt_s  = cmd_imm;
                    rsp_ovf_nxt_s   = 1'b0;
                    rsp_carry_nxt_s = 1'b0;
                    rsp_err_nxt_s   = 1'b0;
                end else if (is_abs(cmd_op)) begin
                    state_nxt_s = SIGN;
                end else begin
                    state_nxt_s  = EXEC;
                    alu_v1_nxt_s = rd_a_s;
                    alu_v2_nxt_s = rd_b_s;
                    alu_op_nxt_s = arith_op(cmd_op);
                end
            end
            SIGN: begin
                if (abs_x_s == NEG_MIN) begin
                    state_nxt_s     = RESP;
                    rsp_data_nxt_s  = NEG_MIN;
                    rsp_ovf_nxt_s   = 1'b1;
                    rsp_carry_nxt_s = 1'b0;
                    rsp_err_nxt_s   = 1'b1;
                end else if (!abs_x_s[W-1]) begin
                    state_nxt_s  = EXEC;
                    alu_v1_nxt_s = abs_x_s;
                    alu_v2_nxt_s = ZERO;
                    alu_op_nxt_s = OP_ADD;
                end else begin
                    state_nxt_s  = EXEC;
                    alu_v1_nxt_s = ZERO;
                    alu_v2_nxt_s = abs_x_s;
                    alu_op_nxt_s = OP_SUB_AB;
                end
            end
            EXEC: begin
                state_nxt_s     = RESP;
                wr_en_s         = 1'b1;
                rsp_data_nxt_s  = alu_r;
                rsp_ovf_nxt_s   = exec_ovf_s;
                rsp_carry_nxt_s = alu_ovf;
                rsp_err_nxt_s   = 1'b0;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, registered outputs and accepted-command fields
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= ZERO;
            rsp_ovf_r   <= 1'b0;
            rsp_carry_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            alu_v1_r    <= ZERO;
            alu_v2_r    <= ZERO;
            alu_op_r    <= OP_ADD;
            dst_r       <= 2'b00;
            op_r        <= 3'b000;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_ovf_r   <= rsp_ovf_nxt_s;
            rsp_carry_r <= rsp_carry_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            alu_v1_r    <= alu_v1_nxt_s;
            alu_v2_r    <= alu_v2_nxt_s;
            alu_op_r    <= alu_op_nxt_s;
            if (fire_s) begin
                dst_r <= cmd_dst;
                op_r  <= cmd_op;
            end
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Table-driven bench for calc_seq_ctrl with a behavioural adder and a response
// scoreboard, plus hand-written backpressure and mid-operation reset sequences.
module tb_calc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_ld;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst, cmd_src_a, cmd_src_b;
    logic [3:0] cmd_imm;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_ovf, rsp_carry, rsp_err;
    logic [3:0] alu_v1, alu_v2, alu_r;
    logic [2:0] alu_op;
    logic       alu_ovf;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;
    logic [4:0] sum_s;

    always #5 clk = ~clk;

    calc_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_op(alu_op), .alu_r(alu_r), .alu_ovf(alu_ovf),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural adder/subtractor; op 101 subtracts V1 from V2
    always_comb begin
        case (alu_op)
            3'b000:  sum_s = {1'b0, alu_v1} + {1'b0, alu_v2};
            3'b001:  sum_s = {1'b0, alu_v1} + {1'b0, ~alu_v2} + 5'd1;
            3'b101:  sum_s = {1'b0, alu_v2} + {1'b0, ~alu_v1} + 5'd1;
            default: sum_s = 5'd0;
        endcase
    end
    assign alu_r   = sum_s[3:0];
    assign alu_ovf = sum_s[4];

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [1:0] dst, sa, sb;
        logic [3:0] imm, edata;
        logic       eovf, ecar, eerr;
        int         elat;
        logic [3:0] ev1, ev2;
        logic [2:0] eop;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic       ovf, car, err;
    } rsp_t;

    rsp_t       sb_q[$];
    vec_t       tbl[21];
    logic [3:0] rf_m[4];
    int         n_pass = 0;
    int         n_total = 0;

    function automatic vec_t mk(logic ld, logic [2:0] op, logic [1:0] dst, logic [1:0] sa,
                                logic [1:0] sb, logic [3:0] imm, logic [3:0] ed, logic eo,
                                logic ec, logic ee, int lat, logic [3:0] v1, logic [3:0] v2,
                                logic [2:0] eop);
        vec_t v;
        v.ld = ld; v.op = op; v.dst = dst; v.sa = sa; v.sb = sb; v.imm = imm;
        v.edata = ed; v.eovf = eo; v.ecar = ec; v.eerr = ee; v.elat = lat;
        v.ev1 = v1; v.ev2 = v2; v.eop = eop;
        return v;
    endfunction

    function automatic vec_t ldv(logic [1:0] dst, logic [3:0] imm);
        return mk(1'b1, 3'b000, dst, 2'd0, 2'd0, imm, imm, 1'b0, 1'b0, 1'b0, 1,
                  4'd0, 4'd0, 3'b000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (cmd_ready !== 1'b1 && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic drive(input vec_t v);
        rsp_t e;
        cmd_ld = v.ld; cmd_op = v.op; cmd_dst = v.dst;
        cmd_src_a = v.sa; cmd_src_b = v.sb; cmd_imm = v.imm;
        cmd_valid = 1'b1;
        e.data = v.edata; e.ovf = v.eovf; e.car = v.ecar; e.err = v.eerr;
        sb_q.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_rsp(input string tag);
        rsp_t e;
        e = sb_q.pop_front();
        chk({tag, "_data"}, {28'd0, rsp_data}, {28'd0, e.data});
        chk({tag, "_ovf"}, {31'd0, rsp_ovf}, {31'd0, e.ovf});
        chk({tag, "_carry"}, {31'd0, rsp_carry}, {31'd0, e.car});
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
    endtask

    task automatic run_vec(input vec_t v);
        int c;
        wait_ready();
        drive(v);
        c = 1;
        while (rsp_valid !== 1'b1 && c < 8) begin
            if (c == v.elat - 1 && !v.ld && !v.eerr) begin
                chk("alu_exec", {21'd0, alu_v1, alu_v2, alu_op}, {21'd0, v.ev1, v.ev2, v.eop});
            end else begin
                chk("alu_quiet", {21'd0, alu_v1, alu_v2, alu_op}, 32'd0);
            end
            @(posedge clk); #1;
            c++;
        end
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("latency", c, v.elat);
        chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        check_rsp("rsp");
        @(posedge clk); #1;
        if (!v.eerr) begin
            rf_m[v.dst] = v.edata;
        end
        dbg_addr = v.dst;
        #1;
        chk("dbg_dst", {28'd0, dbg_data}, {28'd0, rf_m[v.dst]});
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   c;
        tbl[0]  = ldv(2'd0, 4'd3);
        tbl[1]  = ldv(2'd1, 4'd2);
        tbl[2]  = mk(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 4'd0, 4'd5,  1'b0, 1'b0, 1'b0, 2, 4'd3, 4'd2,  3'b000);
        tbl[3]  = ldv(2'd0, 4'd7);
        tbl[4]  = ldv(2'd1, 4'd1);
        tbl[5]  = mk(1'b0, 3'b100, 2'd2, 2'd0, 2'd1, 4'd0, 4'd8,  1'b1, 1'b0, 1'b0, 2, 4'd7, 4'd1,  3'b000);
        tbl[6]  = ldv(2'd0, 4'd3);
        tbl[7]  = ldv(2'd1, 4'd5);
        tbl[8]  = mk(1'b0, 3'b001, 2'd3, 2'd0, 2'd1, 4'd0, 4'd14, 1'b0, 1'b0, 1'b0, 2, 4'd3, 4'd5,  3'b001);
        tbl[9]  = mk(1'b0, 3'b101, 2'd2, 2'd0, 2'd1, 4'd0, 4'd2,  1'b0, 1'b1, 1'b0, 2, 4'd3, 4'd5,  3'b101);
        tbl[10] = ldv(2'd0, 4'd13);
        tbl[11] = mk(1'b0, 3'b110, 2'd1, 2'd0, 2'd2, 4'd0, 4'd3,  1'b0, 1'b0, 1'b0, 3, 4'd0, 4'd13, 3'b001);
        tbl[12] = mk(1'b0, 3'b010, 2'd3, 2'd0, 2'd2, 4'd0, 4'd2,  1'b0, 1'b0, 1'b0, 3, 4'd2, 4'd0,  3'b000);
        tbl[13] = ldv(2'd0, 4'd8);
        tbl[14] = mk(1'b0, 3'b111, 2'd1, 2'd0, 2'd3, 4'd0, 4'd8,  1'b1, 1'b0, 1'b1, 2, 4'd0, 4'd0,  3'b000);
        tbl[15] = ldv(2'd2, 4'd9);
        tbl[16] = mk(1'b0, 3'b000, 2'd0, 2'd0, 2'd2, 4'd0, 4'd1,  1'b1, 1'b1, 1'b0, 2, 4'd8, 4'd9,  3'b000);
        tbl[17] = ldv(2'd1, 4'd15);
        tbl[18] = mk(1'b0, 3'b011, 2'd2, 2'd3, 2'd1, 4'd0, 4'd1,  1'b0, 1'b0, 1'b0, 3, 4'd0, 4'd15, 3'b001);
        tbl[19] = mk(1'b0, 3'b001, 2'd3, 2'd1, 2'd0, 4'd0, 4'd14, 1'b0, 1'b1, 1'b0, 2, 4'd15, 4'd1, 3'b001);
        tbl[20] = ldv(2'd3, 4'd6);

        for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = 3'b000;
        cmd_dst = 2'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_imm = 4'd0;
        rsp_ready = 1'b1; dbg_addr = 2'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp", {24'd0, rsp_valid, rsp_data, rsp_ovf, rsp_carry, rsp_err}, 32'd0);
        chk("rst_alu", {21'd0, alu_v1, alu_v2, alu_op}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = i[1:0]; #1;
            chk("rst_dbg", {28'd0, dbg_data}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 21; i++) run_vec(tbl[i]);

        // Backpressure: r0 = r0 (1) + r1 (15), response held for 5 cycles
        rsp_ready = 1'b0;
        wait_ready();
        v = mk(1'b0, 3'b000, 2'd0, 2'd0, 2'd1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 2, 4'd1, 4'd15, 3'b000);
        drive(v);
        c = 1;
        while (rsp_valid !== 1'b1 && c < 8) begin
            @(posedge clk); #1;
            c++;
        end
        chk("bp_latency", c, 2);
        check_rsp("bp");
        for (int k = 0; k < 5; k++) begin
            cmd_valid = (k % 2 == 0); cmd_ld = 1'b1; cmd_dst = 2'd0; cmd_imm = 4'd15;
            @(posedge clk); #1;
            chk("bp_hold", {25'd0, rsp_valid, cmd_ready, rsp_data, rsp_carry},
                {25'd0, 1'b1, 1'b0, 4'd0, 1'b1});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rf_m[0] = 4'd0;
        chk("bp_release", {30'd0, cmd_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});
        dbg_addr = 2'd0; #1;
        chk("bp_r0", {28'd0, dbg_data}, {28'd0, rf_m[0]});

        // Reset during EXEC of ADD into r3 (r3 = 6)
        wait_ready();
        v = mk(1'b0, 3'b000, 2'd3, 2'd0, 2'd1, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 2, 4'd0, 4'd15, 3'b000);
        drive(v);
        void'(sb_q.pop_front());
        chk("abort_exec_alu", {21'd0, alu_v1, alu_v2, alu_op}, {21'd0, 4'd0, 4'd15, 3'b000});
        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
        dbg_addr = 2'd3; #1;
        chk("abort_r3", {28'd0, dbg_data}, {28'd0, rf_m[3]});
        chk("abort_outs", {22'd0, rsp_valid, cmd_ready, alu_v1, alu_op}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", {30'd0, cmd_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
